// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a multiplexed 7-segment bus and rebuilds the word being shown on it.
// Each digit dwell has to stay stable for STABLE_CYCLES edges before it is
// captured. A dwell is captured at most once. The captured glyph is decoded
// back to a hex nibble. Once every digit has been seen since the last frame,
// a one-cycle frame_done pulse is issued.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   digit_sel    one-hot digit enable; bit i selects nibble i
//   segment      segment pattern, bit0=a .. bit6=g, active-high
//   value        decoded word; nibble i = value[4i+3:4i]
//   valid_digits bit i set while nibble i holds a legally decoded glyph
//   frame_done   1-cycle pulse on the capture that completes a frame
//   pattern_err  1-cycle pulse on a capture of an illegal pattern
//   err_count    saturating count of illegal captures
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     digit_sel,
    input  logic [6:0]            segment,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     valid_digits,
    output logic                  frame_done,
    output logic                  pattern_err,
    output logic [7:0]            err_count
);

    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES - 1);

    logic [DIGITS-1:0] sel_q;
    logic [6:0]        seg_q;
    logic [7:0]        run_cnt;
    logic              captured;
    logic [DIGITS-1:0] mask;

    logic              same;
    logic              one_hot;
    logic              capture;
    logic              blank;
    logic [4:0]        dec;
    logic [DIGITS-1:0] mask_next;
    logic              frame_hit;

    // The result is {legal, nibble}. A pattern outside the table returns legal=0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        same      = (digit_sel == sel_q) && (segment == seg_q);
        one_hot   = (sel_q != '0) && ((sel_q & (sel_q - DIGITS'(1))) == '0);
        // The run counter counts edges since the last sample change. The
        // capture lands on the edge after it saturates, which is STABLE_CYCLES
        // edges after the inputs first appear.
        capture   = same && (run_cnt == RUN_MAX) && !captured && one_hot;
        blank     = (seg_q == 7'h00);
        dec       = decode(seg_q);
        mask_next = mask | sel_q;
        frame_hit = capture && (&mask_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q        <= '0;
            seg_q        <= '0;
            run_cnt      <= '0;
            captured     <= 1'b0;
            mask         <= '0;
            value        <= '0;
            valid_digits <= '0;
            frame_done   <= 1'b0;
            pattern_err  <= 1'b0;
            err_count    <= '0;
        end else begin
            sel_q       <= digit_sel;
            seg_q       <= segment;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;

            if (!same) begin
                run_cnt  <= '0;
                captured <= 1'b0;
            end else begin
                if (run_cnt < RUN_MAX) begin
                    run_cnt <= run_cnt + 8'd1;
                end
                if (capture) begin
                    captured <= 1'b1;
                end
            end

            if (capture) begin
                mask       <= frame_hit ? '0 : mask_next;
                frame_done <= frame_hit;
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel_q[i]) begin
                        if (dec[4]) begin
                            value[4*i +: 4] <= dec[3:0];
                            valid_digits[i] <= 1'b1;
                        end else if (blank) begin
                            value[4*i +: 4] <= 4'h0;
                            valid_digits[i] <= 1'b0;
                        end else begin
                            // An illegal glyph keeps the old nibble but marks it invalid.
                            valid_digits[i] <= 1'b0;
                        end
                    end
                end
                if (!dec[4] && !blank) begin
                    pattern_err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Drives digit dwells onto the bus, which are either directed or random.
// Each dwell is a whole event, described as {select, pattern, hold length}. A
// dwell is captured exactly when its select is one-hot and it is held past
// STABLE_CYCLES edges. The reference model applies that rule and predicts the
// full output snapshot for every clock edge. It pushes each prediction onto
// exp_q. A separate monitor pops one entry after each edge and compares it.
module tb_seg7_scan_decoder;

  localparam int D = 4;
  localparam int S = 4;
  localparam int W = 5 * D + 10;

  logic           clk;
  logic           rst;
  logic [D-1:0]   digit_sel;
  logic [6:0]     segment;
  logic [4*D-1:0] value;
  logic [D-1:0]   valid_digits;
  logic           frame_done;
  logic           pattern_err;
  logic [7:0]     err_count;

  seg7_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_sel    (digit_sel),
    .segment      (segment),
    .value        (value),
    .valid_digits (valid_digits),
    .frame_done   (frame_done),
    .pattern_err  (pattern_err),
    .err_count    (err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [6:0] tbl[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]   m_val[D];
  logic [D-1:0] m_valid;
  logic [D-1:0] m_mask;
  int           m_err;
  logic [D-1:0] last_sel;
  logic [6:0]   last_seg;

  function automatic logic [W-1:0] snap(input logic fd, input logic pe);
    logic [4*D-1:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = m_val[i];
    return {v, m_valid, fd, pe, 8'(m_err)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_val[i] = 4'h0;
    m_valid = '0;
    m_mask  = '0;
    m_err   = 0;
  endtask

  // The model's view of a capture. It returns the two pulse values.
  task automatic model_capture(input logic [D-1:0] sel, input logic [6:0] seg,
                               output logic fd, output logic pe);
    int idx;
    int nib;
    idx = 0;
    nib = -1;
    fd  = 1'b0;
    pe  = 1'b0;
    for (int i = 0; i < D; i++) if (sel[i]) idx = i;
    for (int j = 0; j < 16; j++) if (tbl[j] == seg) nib = j;
    if (nib >= 0) begin
      m_val[idx]   = 4'(nib);
      m_valid[idx] = 1'b1;
    end else if (seg == 7'h00) begin
      m_val[idx]   = 4'h0;
      m_valid[idx] = 1'b0;
    end else begin
      m_valid[idx] = 1'b0;
      pe = 1'b1;
      if (m_err < 255) m_err = m_err + 1;
    end
    m_mask[idx] = 1'b1;
    if (&m_mask) begin
      fd     = 1'b1;
      m_mask = '0;
    end
  endtask

  // driver tasks
  task automatic dwell_raw(input logic [D-1:0] sel, input logic [6:0] seg, input int len);
    logic fd;
    logic pe;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      rst       = 1'b0;
      digit_sel = sel;
      segment   = seg;
      fd = 1'b0;
      pe = 1'b0;
      if (k == S && $countones(sel) == 1) model_capture(sel, seg, fd, pe);
      exp_q.push_back(snap(fd, pe));
    end
    last_sel = sel;
    last_seg = seg;
  endtask

  // If a dwell repeats the previous one, a one-cycle separator is inserted
  // first. Without it the two dwells would merge into a single dwell.
  task automatic dwell(input logic [D-1:0] sel, input logic [6:0] seg, input int len);
    if (sel == last_sel && seg == last_seg) dwell_raw('0, seg ^ 7'h7F, 1);
    dwell_raw(sel, seg, len);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst       = 1'b1;
      digit_sel = '0;
      segment   = 7'h00;
      model_clear();
      exp_q.push_back(snap(1'b0, 1'b0));
    end
    last_sel = '0;
    last_seg = 7'h00;
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {value, valid_digits, frame_done, pattern_err, err_count};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL snapshot cyc=%0d got val=%h vld=%b fd=%b pe=%b ec=%0d exp val=%h vld=%b fd=%b pe=%b ec=%0d",
                   cyc, a[W-1 -: 4*D], a[D+9:10], a[9], a[8], a[7:0],
                   e[W-1 -: 4*D], e[D+9:10], e[9], e[8], e[7:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [D-1:0] rs;
    logic [6:0]   rg;
    int           drain;
    rst       = 1'b1;
    digit_sel = '0;
    segment   = 7'h00;
    model_clear();
    last_sel = '0;
    last_seg = 7'h00;
    do_reset(2);

    // A single stable dwell gives exactly one capture, after edge 4.
    dwell(4'b0001, 7'h5B, 6);

    // A full scan. The frame completes on the digit-3 capture.
    dwell(4'b0001, 7'h06, 5);
    dwell(4'b0010, 7'h4F, 5);
    dwell(4'b0100, 7'h66, 5);
    dwell(4'b1000, 7'h71, 5);

    // The glitch dwell is too short to capture.
    dwell(4'b0010, 7'h7F, 3);
    dwell(4'b0010, 7'h6F, 5);

    // An illegal pattern after a legal C, then enough dwells to saturate err_count.
    dwell(4'b0100, 7'h39, 5);
    dwell(4'b0100, 7'h2A, 5);
    for (int n = 0; n < 300; n++) dwell(4'b0100, 7'h2A, 5);

    // Selects that are not one-hot never capture. A blank capture still counts toward the frame.
    dwell(4'b0110, 7'h06, 10);
    dwell(4'b0000, 7'h06, 10);
    dwell(4'b0001, 7'h3F, 5);
    dwell(4'b0010, 7'h77, 5);
    dwell(4'b0100, 7'h5E, 5);
    dwell(4'b1000, 7'h00, 5);

    // A reset mid-frame. The next frame needs all four captures.
    dwell(4'b0001, 7'h07, 5);
    dwell(4'b0010, 7'h7D, 5);
    do_reset(2);
    dwell(4'b0001, 7'h6D, 5);
    dwell(4'b0010, 7'h79, 5);
    dwell(4'b0100, 7'h7C, 5);
    dwell(4'b1000, 7'h66, 5);

    // random dwells
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) < 8) rs = D'(1) << $urandom_range(0, D - 1);
      else rs = D'($urandom);
      case ($urandom_range(0, 9))
        0:       rg = 7'h00;
        1:       rg = 7'($urandom);
        default: rg = tbl[$urandom_range(0, 15)];
      endcase
      dwell(rs, rg, $urandom_range(1, 8));
    end

    // Let the monitor drain the queue, within a bounded number of cycles.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
